// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the handshaked pipeline stage: default widths, the
// bubble instruction and the stage occupancy encoding.
package pipe_stage_skid_pkg;

  localparam int          XLEN     = 32;
  localparam int          INST_LEN = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          SB_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One payload slot {addr, data, sb} with a load enable; the stage keeps two of
// these (MAIN and SKID).
module pipe_stage_skid_slot #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int SB_W   = 4
) (
  input  logic              clk,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [INST_W-1:0] i_data,
  input  logic [SB_W-1:0]   i_sb,
  output logic [ADDR_W-1:0] o_addr,
  output logic [INST_W-1:0] o_data,
  output logic [SB_W-1:0]   o_sb
);

  logic [ADDR_W-1:0] r_addr;
  logic [INST_W-1:0] r_data;
  logic [SB_W-1:0]   r_sb;

  // NOTE: payload registers carry no reset; validity lives in the stage FSM,
  // and unreset datapath flops stay cheap and never leak since outputs are masked.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_addr <= i_addr;
      r_data <= i_data;
      r_sb   <= i_sb;
    end
  end

  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_sb   = r_sb;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage with a 2-entry skid buffer, flush and NOP bubbles.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                ADDR_W  = XLEN,
  parameter int                INST_W  = INST_LEN,
  parameter int                SB_W    = SB_W_DEF,
  parameter logic [INST_W-1:0] NOP_VAL = INST_W'(INST_NOP),
  parameter int                CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_inst_addr,
  input  logic [INST_W-1:0] i_inst_data,
  input  logic [SB_W-1:0]   i_sb,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_inst_addr,
  output logic [INST_W-1:0] o_inst_data,
  output logic [SB_W-1:0]   o_sb,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  pipe_state_e r_state, w_state_nxt;
  logic        w_in_fire, w_out_fire;
  logic        w_load_main, w_load_skid, w_main_from_skid;

  logic [ADDR_W-1:0] w_main_addr, w_skid_addr, w_main_addr_in;
  logic [INST_W-1:0] w_main_data, w_skid_data, w_main_data_in;
  logic [SB_W-1:0]   w_main_sb,   w_skid_sb,   w_main_sb_in;

  // Handshake outputs decode registered state only; no path from i_ready.
  assign o_valid    = (r_state != ST_EMPTY);
  assign o_ready    = (r_state != ST_FULL);
  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    unique case (r_state)
      ST_EMPTY: if (w_in_fire) begin
        w_load_main = 1'b1;
        w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main = 1'b1;
        end else if (w_in_fire) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: if (w_out_fire) begin
        w_load_main      = 1'b1;
        w_main_from_skid = 1'b1;
        w_state_nxt      = ST_BUSY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
    end
  end

  assign w_main_addr_in = w_main_from_skid ? w_skid_addr : i_inst_addr;
  assign w_main_data_in = w_main_from_skid ? w_skid_data : i_inst_data;
  assign w_main_sb_in   = w_main_from_skid ? w_skid_sb   : i_sb;

  pipe_stage_skid_slot #(.ADDR_W(ADDR_W), .INST_W(INST_W), .SB_W(SB_W)) u_main (
    .clk    (clk),
    .i_load (w_load_main),
    .i_addr (w_main_addr_in),
    .i_data (w_main_data_in),
    .i_sb   (w_main_sb_in),
    .o_addr (w_main_addr),
    .o_data (w_main_data),
    .o_sb   (w_main_sb)
  );

  pipe_stage_skid_slot #(.ADDR_W(ADDR_W), .INST_W(INST_W), .SB_W(SB_W)) u_skid (
    .clk    (clk),
    .i_load (w_load_skid),
    .i_addr (i_inst_addr),
    .i_data (i_inst_data),
    .i_sb   (i_sb),
    .o_addr (w_skid_addr),
    .o_data (w_skid_data),
    .o_sb   (w_skid_sb)
  );

  // Downstream sees a clean NOP bubble whenever nothing valid is held.
  assign o_inst_addr = o_valid ? w_main_addr : '0;
  assign o_inst_data = o_valid ? w_main_data : NOP_VAL;
  assign o_sb        = o_valid ? w_main_sb   : '0;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

  // Saturating counters; only rst clears them, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (o_valid && !i_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!o_valid && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`else
  assign o_stall_cnt  = '0;
  assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; counter expectations follow
// whether PIPE_PERF_CNT_EN is defined for the build.
module tb_pipe_stage_skid;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int SB_W   = 4;
  localparam int CNT_W  = 4;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid, o_ready, i_flush, o_valid, i_ready;
  logic [ADDR_W-1:0] i_inst_addr, o_inst_addr;
  logic [INST_W-1:0] i_inst_data, o_inst_data;
  logic [SB_W-1:0]   i_sb, o_sb;
  logic [CNT_W-1:0]  o_stall_cnt, o_bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .SB_W(SB_W), .NOP_VAL(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_inst_addr  (i_inst_addr),
    .i_inst_data  (i_inst_data),
    .i_sb         (i_sb),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_inst_addr  (o_inst_addr),
    .o_inst_data  (o_inst_data),
    .o_sb         (o_sb),
    .o_stall_cnt  (o_stall_cnt),
    .o_bubble_cnt (o_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    i_valid     = v;
    i_inst_addr = a;
    i_inst_data = d;
    i_sb        = s;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, 64'(o_valid), 64'd0);
    check({tag, ".ready"}, 64'(o_ready), 64'd1);
    check({tag, ".data"},  64'(o_inst_data), 64'(NOP));
    check({tag, ".addr"},  64'(o_inst_addr), 64'd0);
    check({tag, ".sb"},    64'(o_sb), 64'd0);
  endtask

  task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic rdy);
    check({tag, ".valid"}, 64'(o_valid), 64'd1);
    check({tag, ".ready"}, 64'(o_ready), 64'(rdy));
    check({tag, ".addr"},  64'(o_inst_addr), 64'(a));
    check({tag, ".data"},  64'(o_inst_data), 64'(d));
    check({tag, ".sb"},    64'(o_sb), 64'(s));
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
    drive(1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 4'hF);

    // Reset held two cycles with upstream valid asserted
    tick(); tick();
    check_bubble("reset");
    check("reset.stall", 64'(o_stall_cnt), 64'd0);
    check("reset.bubble_cnt", 64'(o_bubble_cnt), 64'd0);

    // Streaming at full throughput
    rst = 1'b0; i_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 32'h0000_0101, 4'h1); tick();
    check_out("stream0", 32'h8000_0000, 32'h0000_0101, 4'h1, 1'b1);
    drive(1'b1, 32'h8000_0004, 32'h0000_0202, 4'h2); tick();
    check_out("stream1", 32'h8000_0004, 32'h0000_0202, 4'h2, 1'b1);
    drive(1'b1, 32'h8000_0008, 32'h0000_0303, 4'h3); tick();
    check_out("stream2", 32'h8000_0008, 32'h0000_0303, 4'h3, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 4'h0); tick();
    check_bubble("stream_drain");

    // Backpressure: A then B fill both slots, C waits upstream
    i_ready = 1'b0;
    drive(1'b1, 32'h0000_0100, 32'hAAAA_0001, 4'h2); tick();
    check_out("bp_a", 32'h0000_0100, 32'hAAAA_0001, 4'h2, 1'b1);
    drive(1'b1, 32'h0000_0104, 32'hBBBB_0002, 4'h4); tick();
    check_out("bp_full", 32'h0000_0100, 32'hAAAA_0001, 4'h2, 1'b0);
    drive(1'b1, 32'h0000_0108, 32'hCCCC_0003, 4'h8); tick();
    check_out("bp_hold", 32'h0000_0100, 32'hAAAA_0001, 4'h2, 1'b0);
    i_ready = 1'b1; tick();
    check_out("bp_b", 32'h0000_0104, 32'hBBBB_0002, 4'h4, 1'b1);
    tick();
    check_out("bp_c", 32'h0000_0108, 32'hCCCC_0003, 4'h8, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 4'h0); tick();
    check_bubble("bp_drain");

    // Flush from FULL while D is offered
    i_ready = 1'b0;
    drive(1'b1, 32'h0000_0200, 32'h1111_0000, 4'h1); tick();
    drive(1'b1, 32'h0000_0204, 32'h2222_0000, 4'h2); tick();
    check("flush_pre.ready", 64'(o_ready), 64'd0);
    i_flush = 1'b1;
    drive(1'b1, 32'h0000_0DDD, 32'hDDDD_DDDD, 4'h5); tick();
    check_bubble("flush");
    i_flush = 1'b0; i_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'h0); tick();
    check_bubble("flush_after");

    // Reset in FULL without flush
    i_ready = 1'b0;
    drive(1'b1, 32'h0000_0300, 32'h3333_0000, 4'h3); tick();
    drive(1'b1, 32'h0000_0304, 32'h4444_0000, 4'h4); tick();
    check("rst_mid_pre.ready", 64'(o_ready), 64'd0);
    rst = 1'b1; tick();
    check_bubble("rst_mid");
    check("rst_mid.stall", 64'(o_stall_cnt), 64'd0);
    rst = 1'b0; i_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'h0); tick();
    check_bubble("rst_mid_after");

    // Perf counters: fresh reset, then stall and saturate
    rst = 1'b1; i_ready = 1'b0; tick();
    rst = 1'b0;
    drive(1'b1, 32'h0000_0400, 32'h5555_0000, 4'h6); tick();  // bubble cycle counted
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) tick();
`ifdef PIPE_PERF_CNT_EN
    check("perf.stall5", 64'(o_stall_cnt), 64'd5);
    check("perf.bubble1", 64'(o_bubble_cnt), 64'd1);
`else
    check("perf.stall5", 64'(o_stall_cnt), 64'd0);
    check("perf.bubble1", 64'(o_bubble_cnt), 64'd0);
`endif
    for (int i = 0; i < 20; i++) tick();
`ifdef PIPE_PERF_CNT_EN
    check("perf.stall_sat", 64'(o_stall_cnt), 64'd15);
`else
    check("perf.stall_sat", 64'(o_stall_cnt), 64'd0);
`endif
    i_flush = 1'b1; tick();
    i_flush = 1'b0; tick();
`ifdef PIPE_PERF_CNT_EN
    check("perf.stall_flush", 64'(o_stall_cnt), 64'd15);
    check("perf.bubble_flush", 64'(o_bubble_cnt), 64'd2);
`else
    check("perf.stall_flush", 64'(o_stall_cnt), 64'd0);
    check("perf.bubble_flush", 64'(o_bubble_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic handshaked pipeline stage register. Successor to the fixed, always-enabled IF/ID latch.
- Carries instruction address, instruction word and a sideband field between two pipeline stages.
- Adds valid/ready backpressure, a 2-entry skid buffer so upstream ready is registered, synchronous flush and NOP bubble insertion.
- Instanced at IF/ID first, then at ID/EX and later stage boundaries.

Parameters:
- ADDR_W, `XLEN, width of the address field.
- INST_W, `INST_LEN, width of the instruction field.
- SB_W, 4, sideband width (fetch fault, predicted-taken, etc.); must be >= 1.
- NOP_VAL, `INST_NOP, instruction value presented whenever the output is not valid.
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  upstream payload valid
- o_ready  out  1  stage can accept (registered)
- i_inst_addr  in  ADDR_W  upstream address
- i_inst_data  in  INST_W  upstream instruction
- i_sb  in  SB_W  upstream sideband
- i_flush  in  1  discard all held and incoming payloads
- o_valid  out  1  downstream payload valid
- i_ready  in  1  downstream accepts
- o_inst_addr  out  ADDR_W  held address
- o_inst_data  out  INST_W  held instruction
- o_sb  out  SB_W  held sideband
- o_stall_cnt  out  CNT_W  cycles with o_valid=1 and i_ready=0
- o_bubble_cnt  out  CNT_W  cycles with o_valid=0

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Fire events:
  - in_fire = i_valid & o_ready.
  - out_fire = o_valid & i_ready.
- Storage: two payload slots, MAIN and SKID. State is EMPTY, BUSY (MAIN valid) or FULL (MAIN and SKID valid).
- Derived outputs: o_valid = (state != EMPTY); o_ready = (state != FULL). Both are decoded from registered state only, with no combinational path from i_ready.
- Transitions (when not flushing):
  - EMPTY: in_fire -> load MAIN, go BUSY.
  - BUSY, in_fire & out_fire: load MAIN with new payload, stay BUSY.
  - BUSY, in_fire & !out_fire: load SKID, go FULL.
  - BUSY, !in_fire & out_fire: go EMPTY.
  - FULL: input is ignored (o_ready=0). out_fire -> MAIN <= SKID, go BUSY.
- Latency: payload accepted in cycle N appears on the outputs in cycle N+1 when the stage was EMPTY, or BUSY with out_fire. Throughput is 1 per cycle.
- Ordering: payloads leave in acceptance order, with no loss or duplication.
- Hold: while o_valid=1 and i_ready=0, all outputs hold stable.
- Bubble: when o_valid=0, outputs are forced to o_inst_data=NOP_VAL, o_inst_addr=0, o_sb=0.
- Flush: i_flush=1 sends next state to EMPTY from any state. It overrides a simultaneous in_fire; that payload is dropped. o_ready=1 next cycle.
- Reset: rst=1 (including mid-operation) gives next state EMPTY, which means o_valid=0, o_ready=1 and bubble outputs; rst also clears the counters. rst has priority over i_flush.
- Slot data registers are not required to be cleared. Only the valid state is reset.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - o_stall_cnt increments each cycle with o_valid & !i_ready.
  - o_bubble_cnt increments each cycle with !o_valid.
  - Both saturate at 2^CNT_W-1, are cleared only by rst (not by i_flush), and do not count during a rst cycle.
- Undefined: no counter registers are built. Both ports are tied to 0; the ports exist in both builds so instantiations stay uniform.

Decomposition:
- sysconfig.v already supplies `XLEN, `INST_LEN and `INST_NOP.
- New shared header pipe_defs.v holds the state encodings `PIPE_ST_EMPTY=2'd0, `PIPE_ST_BUSY=2'd1 and `PIPE_ST_FULL=2'd2, plus the default SB_W.
- One natural sub-module: pipe_slot, a payload register {addr, data, sb} with load enable, built on regTemplate and instanced twice (MAIN, SKID).
- The FSM and counters stay in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles with i_valid=1 -> o_valid=0, o_ready=1, o_inst_data=0x00000013, o_inst_addr=0, o_sb=0.
- Streaming: i_ready=1, i_valid=1, addresses 0x80000000/0x80000004/0x80000008 on consecutive cycles -> each appears one cycle later, o_ready stays 1, no gaps.
- Backpressure: i_ready=0, send A then B -> FULL, o_ready=0, o_valid=1 showing A stable. Upstream holds C. Raise i_ready -> A, B, C out in order on consecutive cycles, no duplicates.
- Flush: in FULL assert i_flush with i_valid=1 carrying D -> next cycle o_valid=0, o_inst_data=NOP, o_ready=1, and D never appears.
- Reset mid-operation in FULL with i_flush=0 -> identical response to the first (Reset) scenario; previously held payloads never appear.
- Perf counters:
  - With PIPE_PERF_CNT_EN and CNT_W=4, hold o_valid=1, i_ready=0 for 5 cycles -> o_stall_cnt=5.
  - Continue for 20 cycles -> o_stall_cnt=15 (saturated).
  - Assert i_flush -> o_stall_cnt unchanged.
  - Without the macro -> both counters read 0 throughout.
